// File: rtl/core_debug_controller.sv
// Run-control sequencer: gates the core clock via core_en for run/halt/step and detects completion.
// Optional breakpoint comparator built when CORE_DBG_BREAKPOINT_EN is defined (adds port bp_hit).
//
// state    | meaning
// HALTED   | core frozen, waiting for a command
// RUNNING  | core_en held high until HALT, breakpoint or done
// STEPPING | core_en high for step_left more cycles, commands blocked
// FINISHED | program complete, core frozen until reset
module core_debug_controller #(
    parameter int STEP_W = 8,
    parameter int PC_W   = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [STEP_W-1:0] cmd_arg,
    input  logic [PC_W-1:0]   pc_in,
    input  logic              done_in,
    output logic              core_en,
    output logic              halted,
    output logic [1:0]        state_out,
    output logic [STEP_W-1:0] step_left,
`ifdef CORE_DBG_BREAKPOINT_EN
    output logic              bp_hit,
`endif
    output logic              resp_valid
);

    typedef enum logic [1:0] {
        HALTED   = 2'b00,
        RUNNING  = 2'b01,
        STEPPING = 2'b10,
        FINISHED = 2'b11
    } state_t;

    localparam logic [1:0] OP_RUN    = 2'b00;
    localparam logic [1:0] OP_HALT   = 2'b01;
    localparam logic [1:0] OP_STEP   = 2'b10;
    localparam logic [1:0] OP_SET_BP = 2'b11;

    state_t            state, state_nxt;
    logic [STEP_W-1:0] step_nxt;
    logic              resp_nxt;
    logic              accept;
    logic              bp_match;
    logic              bp_hit_nxt;

    assign core_en   = (state == RUNNING) || (state == STEPPING);
    assign halted    = (state == HALTED) || (state == FINISHED);
    assign cmd_ready = (state != STEPPING);
    assign state_out = state;
    assign accept    = cmd_valid && cmd_ready;

`ifdef CORE_DBG_BREAKPOINT_EN
    logic [PC_W-1:0] bp_pc;
    logic            bp_armed;

    assign bp_match = bp_armed && (pc_in == bp_pc) && core_en;

    always_ff @(posedge clock) begin
        if (reset) begin
            bp_pc    <= '0;
            bp_armed <= 1'b0;
            bp_hit   <= 1'b0;
        end else begin
            bp_hit <= bp_hit_nxt;
            // FINISHED swallows every command, SET_BP included
            if (accept && cmd_op == OP_SET_BP && state != FINISHED) begin
                bp_pc    <= cmd_arg[PC_W-1:0];
                bp_armed <= ~cmd_arg[STEP_W-1];
            end
        end
    end
`else
    logic unused_pc;
    assign unused_pc = ^pc_in;
    assign bp_match  = 1'b0;
`endif

    always_comb begin
        state_nxt  = state;
        step_nxt   = step_left;
        resp_nxt   = 1'b0;
        bp_hit_nxt = 1'b0;
        unique case (state)
            HALTED: begin
                if (accept) begin
                    unique case (cmd_op)
                        OP_RUN: begin
                            state_nxt = RUNNING;
                            resp_nxt  = 1'b1;
                        end
                        OP_STEP: begin
                            if (cmd_arg != '0) begin
                                state_nxt = STEPPING;
                                step_nxt  = cmd_arg;
                            end else begin
                                resp_nxt = 1'b1;
                            end
                        end
                        default: resp_nxt = 1'b1;
                    endcase
                end
            end
            RUNNING: begin
                resp_nxt = accept;
                if (done_in) begin
                    state_nxt = FINISHED;
                    step_nxt  = '0;
                    resp_nxt  = 1'b1;
                end else if (bp_match) begin
                    state_nxt  = HALTED;
                    resp_nxt   = 1'b1;
                    bp_hit_nxt = 1'b1;
                end else if (accept && cmd_op == OP_HALT) begin
                    state_nxt = HALTED;
                end
            end
            STEPPING: begin
                // every exit from a step sequence acknowledges the original STEP
                if (done_in) begin
                    state_nxt = FINISHED;
                    step_nxt  = '0;
                    resp_nxt  = 1'b1;
                end else if (bp_match) begin
                    state_nxt  = HALTED;
                    step_nxt   = '0;
                    resp_nxt   = 1'b1;
                    bp_hit_nxt = 1'b1;
                end else if (step_left == STEP_W'(1)) begin
                    state_nxt = HALTED;
                    step_nxt  = '0;
                    resp_nxt  = 1'b1;
                end else begin
                    step_nxt = step_left - 1'b1;
                end
            end
            FINISHED: begin
                resp_nxt = accept;
            end
            default: state_nxt = HALTED;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= HALTED;
            step_left  <= '0;
            resp_valid <= 1'b0;
        end else begin
            state      <= state_nxt;
            step_left  <= step_nxt;
            resp_valid <= resp_nxt;
        end
    end

endmodule

// File: tb/tb_core_debug_controller.sv
// Directed bench for core_debug_controller: per-cycle expected snapshots are queued as stimulus
// is driven and popped/compared one cycle at a time after each posedge.
module tb_core_debug_controller;

    localparam int STEP_W = 8;
    localparam int PC_W   = 5;

    localparam logic [1:0] ST_H = 2'b00;
    localparam logic [1:0] ST_R = 2'b01;
    localparam logic [1:0] ST_S = 2'b10;
    localparam logic [1:0] ST_F = 2'b11;

    localparam logic [1:0] OP_RUN    = 2'b00;
    localparam logic [1:0] OP_HALT   = 2'b01;
    localparam logic [1:0] OP_STEP   = 2'b10;
    localparam logic [1:0] OP_SET_BP = 2'b11;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [1:0]        cmd_op = 2'b00;
    logic [STEP_W-1:0] cmd_arg = '0;
    logic [PC_W-1:0]   pc_in = '0;
    logic              done_in = 1'b0;
    logic              core_en;
    logic              halted;
    logic [1:0]        state_out;
    logic [STEP_W-1:0] step_left;
    logic              resp_valid;
    logic              bp_hit_obs;

    typedef struct packed {
        logic [1:0]        st;
        logic              en;
        logic              hl;
        logic              rdy;
        logic [STEP_W-1:0] sl;
        logic              rv;
        logic              bh;
    } snap_t;

    snap_t exp_q[$];
    string tag_q[$];
    int    total  = 0;
    int    passed = 0;

`ifdef CORE_DBG_BREAKPOINT_EN
    logic bp_hit;
    assign bp_hit_obs = bp_hit;
`else
    assign bp_hit_obs = 1'b0;
`endif

    core_debug_controller #(.STEP_W(STEP_W), .PC_W(PC_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_arg    (cmd_arg),
        .pc_in      (pc_in),
        .done_in    (done_in),
        .core_en    (core_en),
        .halted     (halted),
        .state_out  (state_out),
        .step_left  (step_left),
`ifdef CORE_DBG_BREAKPOINT_EN
        .bp_hit     (bp_hit),
`endif
        .resp_valid (resp_valid)
    );

    always #5 clock = ~clock;

    // Derived flags follow the architectural definition of each state.
    function automatic snap_t mk(input logic [1:0] st, input logic [STEP_W-1:0] sl,
                                 input logic rv, input logic bh);
        snap_t s;
        s.st  = st;
        s.en  = (st == ST_R) || (st == ST_S);
        s.hl  = (st == ST_H) || (st == ST_F);
        s.rdy = (st != ST_S);
        s.sl  = sl;
        s.rv  = rv;
        s.bh  = bh;
        return s;
    endfunction

    task automatic expect_snap(input string tag, input logic [1:0] st,
                               input logic [STEP_W-1:0] sl, input logic rv, input logic bh);
        exp_q.push_back(mk(st, sl, rv, bh));
        tag_q.push_back(tag);
    endtask

    task automatic send(input logic [1:0] op, input logic [STEP_W-1:0] arg);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
    endtask

    // One clock: sample 1ns after the edge, drop the command, compare against the queue head.
    task automatic tick();
        snap_t obs;
        snap_t e;
        string tag;
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
        obs = {state_out, core_en, halted, cmd_ready, step_left, resp_valid, bp_hit_obs};
        total++;
        if (exp_q.size() == 0) begin
            $error("FAIL scoreboard_empty: observed %h required an expectation entry", obs);
        end else begin
            e   = exp_q.pop_front();
            tag = tag_q.pop_front();
            assert (obs === e) passed++;
            else $error("FAIL %s: observed st=%0d en=%0b hl=%0b rdy=%0b sl=%0d rv=%0b bh=%0b required st=%0d en=%0b hl=%0b rdy=%0b sl=%0d rv=%0b bh=%0b",
                        tag, obs.st, obs.en, obs.hl, obs.rdy, obs.sl, obs.rv, obs.bh,
                        e.st, e.en, e.hl, e.rdy, e.sl, e.rv, e.bh);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        // reset then idle
        reset = 1'b1;
        expect_snap("reset0", ST_H, 0, 0, 0);
        expect_snap("reset1", ST_H, 0, 0, 0);
        ticks(2);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) expect_snap("idle", ST_H, 0, 0, 0);
        ticks(3);

        // STEP 3: three enabled cycles, then HALTED with the acknowledgement
        send(OP_STEP, 8'd3);
        expect_snap("step3_a", ST_S, 3, 0, 0);
        expect_snap("step3_b", ST_S, 2, 0, 0);
        expect_snap("step3_c", ST_S, 1, 0, 0);
        expect_snap("step3_done", ST_H, 0, 1, 0);
        expect_snap("step3_idle", ST_H, 0, 0, 0);
        ticks(5);

        // RUN at t, HALT at t+5
        send(OP_RUN, 8'd0);
        expect_snap("run_ack", ST_R, 0, 1, 0);
        for (int i = 0; i < 4; i++) expect_snap("running", ST_R, 0, 0, 0);
        ticks(5);
        send(OP_HALT, 8'd0);
        expect_snap("halt_ack", ST_H, 0, 1, 0);
        expect_snap("halt_idle", ST_H, 0, 0, 0);
        ticks(2);

        // done_in with simultaneous HALT: done wins
        send(OP_RUN, 8'd0);
        expect_snap("run2_ack", ST_R, 0, 1, 0);
        tick();
        done_in = 1'b1;
        send(OP_HALT, 8'd0);
        expect_snap("finish_entry", ST_F, 0, 1, 0);
        tick();
        done_in = 1'b0;
        expect_snap("finish_hold", ST_F, 0, 0, 0);
        tick();
        send(OP_RUN, 8'd0);
        expect_snap("finish_run_ack", ST_F, 0, 1, 0);
        expect_snap("finish_stuck", ST_F, 0, 0, 0);
        ticks(2);
        reset = 1'b1;
        expect_snap("finish_reset", ST_H, 0, 0, 0);
        tick();
        reset = 1'b0;
        expect_snap("post_reset", ST_H, 0, 0, 0);
        tick();

        // STEP 0: no enable cycle, immediate acknowledgement
        send(OP_STEP, 8'd0);
        expect_snap("step0_ack", ST_H, 0, 1, 0);
        expect_snap("step0_idle", ST_H, 0, 0, 0);
        ticks(2);

        // reset aborts a STEP 10 sequence without a response
        send(OP_STEP, 8'd10);
        expect_snap("step10_a", ST_S, 10, 0, 0);
        expect_snap("step10_b", ST_S, 9, 0, 0);
        expect_snap("step10_c", ST_S, 8, 0, 0);
        ticks(3);
        reset = 1'b1;
        expect_snap("abort_reset", ST_H, 0, 0, 0);
        tick();
        reset = 1'b0;
        expect_snap("abort_quiet0", ST_H, 0, 0, 0);
        expect_snap("abort_quiet1", ST_H, 0, 0, 0);
        ticks(2);

        // STEP 1 boundary
        send(OP_STEP, 8'd1);
        expect_snap("step1_a", ST_S, 1, 0, 0);
        expect_snap("step1_done", ST_H, 0, 1, 0);
        ticks(2);

        // done during STEP clears step_left and acknowledges
        send(OP_STEP, 8'd5);
        expect_snap("step5_a", ST_S, 5, 0, 0);
        tick();
        done_in = 1'b1;
        expect_snap("step_done_fin", ST_F, 0, 1, 0);
        tick();
        done_in = 1'b0;
        reset = 1'b1;
        expect_snap("step_done_reset", ST_H, 0, 0, 0);
        tick();
        reset = 1'b0;

        // SET_BP acknowledged next cycle in either build
        send(OP_SET_BP, 8'h04);
        expect_snap("setbp_ack", ST_H, 0, 1, 0);
        tick();

`ifdef CORE_DBG_BREAKPOINT_EN
        // armed breakpoint at PC 4 halts the cycle after pc_in==4
        send(OP_RUN, 8'd0);
        expect_snap("bp_run_ack", ST_R, 0, 1, 0);
        tick();
        for (int k = 0; k < 8; k++) begin
            pc_in = PC_W'(k);
            if (k < 4)       expect_snap("bp_ramp", ST_R, 0, 0, 0);
            else if (k == 4) expect_snap("bp_hit", ST_H, 0, 1, 1);
            else             expect_snap("bp_after", ST_H, 0, 0, 0);
            tick();
        end

        // disarmed breakpoint: ramp through PC 4 without halting
        pc_in = '0;
        send(OP_SET_BP, 8'h80);
        expect_snap("disarm_ack", ST_H, 0, 1, 0);
        tick();
        send(OP_RUN, 8'd0);
        expect_snap("nobp_run_ack", ST_R, 0, 1, 0);
        tick();
        for (int k = 0; k < 8; k++) begin
            pc_in = PC_W'(k);
            expect_snap("nobp_ramp", ST_R, 0, 0, 0);
            tick();
        end
        send(OP_HALT, 8'd0);
        expect_snap("nobp_halt", ST_H, 0, 1, 0);
        tick();
`else
        // without the feature, pc_in==4 while running must not stop the core
        send(OP_RUN, 8'd0);
        expect_snap("nobp_run_ack", ST_R, 0, 1, 0);
        tick();
        for (int k = 0; k < 8; k++) begin
            pc_in = PC_W'(k);
            expect_snap("nobp_ramp", ST_R, 0, 0, 0);
            tick();
        end
        send(OP_HALT, 8'd0);
        expect_snap("nobp_halt", ST_H, 0, 1, 0);
        tick();
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
